// File: rtl/rlbp_pkg.sv
// rtl/rlbp_pkg.sv - shared constants, FSM encoding and pixel helper for the RLBP feeder
package rlbp_pkg;

    localparam int PIX_W           = 4;
    localparam int NPIX            = 3;
    localparam int TRIP_W          = PIX_W * NPIX;
    localparam int DEFAULT_TIMEOUT = 255;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD1   = 3'd1,
        ST_LOAD2   = 3'd2,
        ST_LOAD3   = 3'd3,
        ST_START   = 3'd4,
        ST_WAIT    = 3'd5,
        ST_RECOVER = 3'd6,
        ST_OUT     = 3'd7
    } state_t;

    // Extract pixel idx (0 = d1) from a packed column triplet.
    function automatic logic [PIX_W-1:0] pick_pixel(input logic [TRIP_W-1:0] trip, input int idx);
        return trip[idx*PIX_W +: PIX_W];
    endfunction

endpackage

// File: rtl/rlbp_feed_fifo.sv
// rtl/rlbp_feed_fifo.sv - synchronous triplet FIFO with full/empty flags
module rlbp_feed_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == DEPTH_CNT);
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];

    // Storage needs no reset: entries are only read when count says they are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rlbp_window_feeder.sv
// rtl/rlbp_window_feeder.sv - buffers pixel triplets and sequences them through the RLBP core
module rlbp_window_feeder
    import rlbp_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_ni,
    input  logic             enable_i,
    input  logic             pix_valid_i,
    output logic             pix_ready_o,
    input  logic [11:0]      pix_data_i,
    output logic [PIX_W-1:0] rlbp_d_o,
    output logic             rlbp_ce_d1_o,
    output logic             rlbp_ce_d2_o,
    output logic             rlbp_ce_d3_o,
    output logic             rlbp_start_o,
    output logic             rlbp_reset_fsm_o,
    input  logic             rlbp_done_i,
    input  logic [PIX_W-1:0] rlbp_data_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [PIX_W-1:0] res_data_o,
    output logic             res_timeout_o,
    output logic             busy_o,
    output logic             err_sticky_o,
    input  logic             clr_err_i
);
    localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

    state_t            state;
    state_t            state_next;
    logic [15:0]       timer;
    logic [TRIP_W-1:0] head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic              timed_out;
    logic [PIX_W-1:0]  d_next;

    assign pix_ready_o = !fifo_full;
    assign pop         = (state == ST_LOAD3);
    assign timed_out   = (state == ST_WAIT) && !rlbp_done_i && (timer == TIMEOUT_CNT);

    rlbp_feed_fifo #(
        .WIDTH (TRIP_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (wb_clk_i),
        .rst_n (wb_rst_ni),
        .push  (pix_valid_i),
        .pop   (pop),
        .wdata (pix_data_i),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // State register.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and the pixel to present in the next cycle; done wins over timeout.
    always_comb begin
        state_next = state;
        d_next     = '0;
        case (state)
            ST_IDLE:    if (enable_i && !fifo_empty) state_next = ST_LOAD1;
            ST_LOAD1:   state_next = ST_LOAD2;
            ST_LOAD2:   state_next = ST_LOAD3;
            ST_LOAD3:   state_next = ST_START;
            ST_START:   state_next = ST_WAIT;
            ST_WAIT: begin
                if (rlbp_done_i) begin
                    state_next = ST_OUT;
                end else if (timer == TIMEOUT_CNT) begin
                    state_next = ST_RECOVER;
                end
            end
            ST_RECOVER: state_next = ST_OUT;
            ST_OUT:     if (res_ready_i) state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
        case (state_next)
            ST_LOAD1: d_next = pick_pixel(head, 0);
            ST_LOAD2: d_next = pick_pixel(head, 1);
            ST_LOAD3: d_next = pick_pixel(head, 2);
            default:  d_next = '0;
        endcase
    end

    // Registered core-side strobes and status decoded from the upcoming state.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            rlbp_d_o         <= '0;
            rlbp_ce_d1_o     <= 1'b0;
            rlbp_ce_d2_o     <= 1'b0;
            rlbp_ce_d3_o     <= 1'b0;
            rlbp_start_o     <= 1'b0;
            rlbp_reset_fsm_o <= 1'b0;
            res_valid_o      <= 1'b0;
            busy_o           <= 1'b0;
        end else begin
            rlbp_d_o         <= d_next;
            rlbp_ce_d1_o     <= (state_next == ST_LOAD1);
            rlbp_ce_d2_o     <= (state_next == ST_LOAD2);
            rlbp_ce_d3_o     <= (state_next == ST_LOAD3);
            rlbp_start_o     <= (state_next == ST_START);
            rlbp_reset_fsm_o <= (state_next == ST_RECOVER);
            res_valid_o      <= (state_next == ST_OUT);
            busy_o           <= (state_next != ST_IDLE);
        end
    end

    // Done-wait timer, result capture and sticky error (set beats clear).
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            timer         <= '0;
            res_data_o    <= '0;
            res_timeout_o <= 1'b0;
            err_sticky_o  <= 1'b0;
        end else begin
            if (state == ST_START) begin
                timer <= '0;
            end else if (state == ST_WAIT && !rlbp_done_i && timer != TIMEOUT_CNT) begin
                timer <= timer + 16'd1;
            end
            if (state == ST_WAIT && rlbp_done_i) begin
                res_data_o    <= rlbp_data_i;
                res_timeout_o <= 1'b0;
            end else if (state == ST_RECOVER) begin
                res_data_o    <= '0;
                res_timeout_o <= 1'b1;
            end
            if (timed_out) begin
                err_sticky_o <= 1'b1;
            end else if (clr_err_i) begin
                err_sticky_o <= 1'b0;
            end
        end
    end

endmodule
